// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and instruction/address constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSN        = 32'h0000_0000;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_timer.sv
// 8-bit saturating wait counter for the fetch stage; flags when the count
// reaches TIMEOUT.
module fetch_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign expired = (r_count == 8'(TIMEOUT));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: latches the aligned PC, runs a req/ack read on the instruction
// memory, holds the returned word in IR and stalls the core while busy.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              phase_f,
  input  logic              hlt,
  input  logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic              fetch_busy,
  output logic              fetch_err
);

  fetch_state_e      r_state;
  fetch_state_e      w_next;
  logic              r_imem_req;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_ir;
  logic              r_ir_valid;
  logic              r_err;

  logic              w_start;
  logic              w_done;
  logic              w_fail;
  logic              w_timer_clr;
  logic              w_timer_en;
  logic              w_expired;
  logic [ADDR_W-1:0] w_pc_aligned;

  assign w_pc_aligned = {pc[ADDR_W-1:2], pc[1:0] & ADDR_ALIGN_MASK[1:0]};

  fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_timer_clr),
    .en      (w_timer_en),
    .expired (w_expired)
  );

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_fail      = 1'b0;
    w_timer_clr = 1'b0;
    w_timer_en  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (phase_f && !hlt) begin
          w_next      = S_REQ;
          w_start     = 1'b1;
          w_timer_clr = 1'b1;
        end
      end
      S_REQ: begin
        // An ack on the expiry cycle still completes the read.
        if (imem_ack) begin
          w_next = S_DONE;
          w_done = 1'b1;
        end else if (w_expired) begin
          w_next = S_ERR;
          w_fail = 1'b1;
        end else begin
          w_timer_en = 1'b1;
        end
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_imem_req <= 1'b0;
      r_addr     <= '0;
      r_ir       <= DATA_W'(NOP_INSN);
      r_ir_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_imem_req <= (w_next == S_REQ);
      if (w_start) begin
        r_addr     <= w_pc_aligned;
        r_ir_valid <= 1'b0;
      end
      if (w_done) begin
        r_ir       <= imem_rdata;
        r_ir_valid <= 1'b1;
      end
      if (w_fail) begin
        r_ir       <= DATA_W'(NOP_INSN);
        r_ir_valid <= 1'b0;
        r_err      <= 1'b1;
      end
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_addr;
  assign ir         = r_ir;
  assign ir_valid   = r_ir_valid;
  assign fetch_err  = r_err;
  assign fetch_busy = (r_state == S_REQ) || (r_state == S_ERR);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: vector table with a one-cycle scoreboard on the
// default-timeout instance, hand sequences for timeout and async reset.
module tb_instruction_fetch;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] ir;
    logic        irv;
    logic        busy;
    logic        err;
  } outs_t;

  typedef struct {
    logic        pf;
    logic        h;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rd;
    outs_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        phase_f;
  logic        hlt;
  logic [31:0] pc;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic        m_req, m_irv, m_busy, m_err;
  logic [31:0] m_addr, m_ir;
  logic        t_req, t_irv, t_busy, t_err;
  logic [31:0] t_addr, t_ir;

  int checks   = 0;
  int failures = 0;

  outs_t q_exp[$];
  vec_t  vecs[18];

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst(rst), .phase_f(phase_f), .hlt(hlt), .pc(pc),
    .imem_req(m_req), .imem_addr(m_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(m_ir), .ir_valid(m_irv),
    .fetch_busy(m_busy), .fetch_err(m_err)
  );

  instruction_fetch #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst(rst), .phase_f(phase_f), .hlt(hlt), .pc(pc),
    .imem_req(t_req), .imem_addr(t_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(t_ir), .ir_valid(t_irv),
    .fetch_busy(t_busy), .fetch_err(t_err)
  );

  function automatic outs_t o(logic rq, logic [31:0] a, logic [31:0] i,
                              logic v, logic b, logic e);
    outs_t r;
    r = '{req: rq, addr: a, ir: i, irv: v, busy: b, err: e};
    return r;
  endfunction

  function automatic vec_t mk(logic pf, logic h, logic [31:0] p, logic a,
                              logic [31:0] rd, outs_t e);
    vec_t v;
    v.pf = pf; v.h = h; v.pc = p; v.ack = a; v.rd = rd; v.exp = e;
    return v;
  endfunction

  function automatic outs_t get_m();
    return o(m_req, m_addr, m_ir, m_irv, m_busy, m_err);
  endfunction

  function automatic outs_t get_t();
    return o(t_req, t_addr, t_ir, t_irv, t_busy, t_err);
  endfunction

  task automatic chko(input string nm, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got req=%b addr=%h ir=%h v=%b busy=%b err=%b, expected req=%b addr=%h ir=%h v=%b busy=%b err=%b",
               nm, act.req, act.addr, act.ir, act.irv, act.busy, act.err,
               exp.req, exp.addr, exp.ir, exp.irv, exp.busy, exp.err);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pf, input logic h, input logic [31:0] p,
                       input logic a, input logic [31:0] rd);
    phase_f = pf; hlt = h; pc = p; imem_ack = a; imem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    outs_t got;

    vecs[0]  = mk(1, 0, 32'h0000_0104, 0, 32'h0,         o(1, 32'h104, 32'h0,         0, 1, 0));
    vecs[1]  = mk(0, 0, 32'h0,         1, 32'hDEAD_BEEF, o(0, 32'h104, 32'hDEAD_BEEF, 1, 0, 0));
    vecs[2]  = mk(0, 0, 32'h0,         1, 32'h1111_1111, o(0, 32'h104, 32'hDEAD_BEEF, 1, 0, 0));
    vecs[3]  = mk(1, 0, 32'h0000_0203, 0, 32'h0,         o(1, 32'h200, 32'hDEAD_BEEF, 0, 1, 0));
    vecs[4]  = mk(0, 0, 32'h0,         0, 32'h0,         o(1, 32'h200, 32'hDEAD_BEEF, 0, 1, 0));
    vecs[5]  = mk(1, 0, 32'h0000_0300, 0, 32'h0,         o(1, 32'h200, 32'hDEAD_BEEF, 0, 1, 0));
    vecs[6]  = mk(0, 0, 32'h0,         0, 32'h0,         o(1, 32'h200, 32'hDEAD_BEEF, 0, 1, 0));
    vecs[7]  = mk(0, 0, 32'h0,         0, 32'h0,         o(1, 32'h200, 32'hDEAD_BEEF, 0, 1, 0));
    vecs[8]  = mk(0, 0, 32'h0,         0, 32'h0,         o(1, 32'h200, 32'hDEAD_BEEF, 0, 1, 0));
    vecs[9]  = mk(0, 0, 32'h0,         1, 32'hCAFE_F00D, o(0, 32'h200, 32'hCAFE_F00D, 1, 0, 0));
    vecs[10] = mk(1, 1, 32'h0000_0400, 0, 32'h0,         o(0, 32'h200, 32'hCAFE_F00D, 1, 0, 0));
    vecs[11] = mk(0, 0, 32'h0,         0, 32'h0,         o(0, 32'h200, 32'hCAFE_F00D, 1, 0, 0));
    vecs[12] = mk(1, 0, 32'h0000_0500, 0, 32'h0,         o(1, 32'h500, 32'hCAFE_F00D, 0, 1, 0));
    vecs[13] = mk(0, 1, 32'h0,         0, 32'h0,         o(1, 32'h500, 32'hCAFE_F00D, 0, 1, 0));
    vecs[14] = mk(0, 1, 32'h0,         1, 32'h1234_5678, o(0, 32'h500, 32'h1234_5678, 1, 0, 0));
    vecs[15] = mk(1, 1, 32'h0000_0600, 0, 32'h0,         o(0, 32'h500, 32'h1234_5678, 1, 0, 0));
    vecs[16] = mk(1, 0, 32'hFFFF_FFFF, 0, 32'h0,         o(1, 32'hFFFF_FFFC, 32'h1234_5678, 0, 1, 0));
    vecs[17] = mk(0, 0, 32'h0,         1, 32'hA5A5_A5A5, o(0, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 1, 0, 0));

    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chko("reset_state", get_m(), o(0, 32'h0, 32'h0, 0, 0, 0));

    // Each vector's expected outputs apply one cycle after its inputs.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].pf, vecs[i].h, vecs[i].pc, vecs[i].ack, vecs[i].rd);
      q_exp.push_back(vecs[i].exp);
      tick();
      got = get_m();
      chko($sformatf("vec%0d", i), got, q_exp.pop_front());
    end

    // Asynchronous reset mid-read, then a late ack.
    drive(1, 0, 32'h0000_0700, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    chk("async_pre_req", {31'b0, m_req}, 32'd1);
    #2 rst = 1'b1;
    #1 chko("async_reset_now", get_m(), o(0, 32'h0, 32'h0, 0, 0, 0));
    #1 rst = 1'b0;
    @(negedge clk);
    drive(0, 0, 32'h0, 1, 32'h0000_0077);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    chko("late_ack_ignored", get_m(), o(0, 32'h0, 32'h0, 0, 0, 0));

    // Timeout instance: load a nonzero IR first so the NOP write is visible.
    pulse_reset();
    @(negedge clk);
    drive(1, 0, 32'h0000_0010, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 1, 32'hBEEF_0001);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    chko("to_first_fetch", get_t(), o(0, 32'h10, 32'hBEEF_0001, 1, 0, 0));

    drive(1, 0, 32'h0000_0020, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    chko("to_req_cycle1", get_t(), o(1, 32'h20, 32'hBEEF_0001, 0, 1, 0));
    n = 0;
    while (!t_err && n < 20) begin
      tick();
      n++;
    end
    chk("timeout_latency", n, 32'd5);
    chko("timeout_state", get_t(), o(0, 32'h20, 32'h0, 0, 1, 1));
    drive(1, 0, 32'h0000_0030, 1, 32'h9999_9999);
    tick();
    tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    chko("err_sticky", get_t(), o(0, 32'h20, 32'h0, 0, 1, 1));
    pulse_reset();
    #1 chko("err_cleared", get_t(), o(0, 32'h0, 32'h0, 0, 0, 0));

    // Ack on the exact expiry cycle: timer hits TIMEOUT in cycle 5.
    @(negedge clk);
    drive(1, 0, 32'h0000_0040, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    for (int c = 1; c <= 4; c++) tick();
    chko("to_cycle5", get_t(), o(1, 32'h40, 32'h0, 0, 1, 0));
    drive(0, 0, 32'h0, 1, 32'h5A5A_0005);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    chko("ack_on_expiry", get_t(), o(0, 32'h40, 32'h5A5A_0005, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that sits directly downstream of the program counter. It captures the next PC during the fetch phase and runs a request/acknowledge read on the instruction memory port. It holds the returned word in the instruction register for the decode/execute phases. It tells the phase generator to stall while a read is outstanding, and flags a memory that never answers.

## Interface
Parameters:
- `ADDR_W`, 32: PC / memory address width.
- `DATA_W`, 32: instruction word width.
- `TIMEOUT`, 255: maximum cycles to wait for `imem_ack` before error; range 1..255.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `phase_f`  in  1  fetch-phase strobe from the phase generator.
- `hlt`  in  1  processor halted; blocks new fetches.
- `pc`  in  ADDR_W  next PC; valid in the `phase_f` cycle.
- `imem_req`  out  1  read request, held until acknowledged.
- `imem_addr`  out  ADDR_W  word-aligned read address.
- `imem_ack`  in  1  read data valid this cycle.
- `imem_rdata`  in  DATA_W  read data.
- `ir`  out  DATA_W  instruction register.
- `ir_valid`  out  1  `ir` holds the word for the current fetch.
- `fetch_busy`  out  1  read outstanding; phase generator must not advance.
- `fetch_err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, REQ, DONE, ERR.
- IDLE: on `phase_f && !hlt`:
  - latch `pc & ~3` into the address register;
  - clear `ir_valid`;
  - clear the timer;
  - go to REQ.
- IDLE: `phase_f` while `hlt` is high is ignored.
- REQ: `imem_req`=1 and `fetch_busy`=1; `imem_addr` is stable.
  - On `imem_ack`: `ir` <= `imem_rdata`, `ir_valid` <= 1, go to DONE.
  - Otherwise the timer increments. When the timer reaches `TIMEOUT` without an ack: `fetch_err` <= 1, `ir` <= NOP (all zeros), `ir_valid` <= 0, go to ERR.
- DONE: behaves like IDLE. `phase_f && !hlt` starts the next fetch the same way; `ir_valid` stays high until that new fetch is accepted.
- ERR: terminal; `imem_req`=0 and `fetch_busy`=1, so the core freezes. Only `rst` exits.
- REQ, `phase_f` arrives: protocol violation; ignored, the address is not re-latched.
- REQ, `hlt` asserts: the read still completes normally. The next fetch is then blocked by the IDLE/DONE rule.
- REQ, `imem_ack` on the cycle the timer reaches `TIMEOUT`: ack wins, no error.
- IDLE/DONE, `imem_ack` arrives: ignored.
- Reset mid-read: `imem_req` drops immediately (asynchronously). A late ack after reset is ignored.
- Reset values:
  - state = IDLE;
  - `imem_req`=0, `imem_addr`=0;
  - `ir`=0 (NOP), `ir_valid`=0;
  - `fetch_busy`=0, `fetch_err`=0;
  - timer=0.
- Address arithmetic: masking only, no increment; an incoming `pc` of all ones yields 0xFFFFFFFC.

## Timing
- Cycle 0: `phase_f` high, `pc` sampled.
- Cycle 1: `imem_req` and `fetch_busy` high, `imem_addr` = latched value.
- Cycle k ≥ 1: `imem_ack` sampled. A zero-wait memory may ack in cycle 1.
- Cycle k+1: `ir`/`ir_valid` updated; `imem_req` and `fetch_busy` low.
- Minimum fetch latency: `phase_f` to `ir_valid` is 2 cycles.
- Timeout: `fetch_err` rises `TIMEOUT`+1 cycles after `imem_req` first rises.
- All outputs are registered except `fetch_busy`, which is decoded from state only (no input paths).
- `imem_req` is never deasserted before an ack except by reset or timeout.

## Structure
- Shared package `cpu_pkg`:
  - fetch state enum (IDLE, REQ, DONE, ERR);
  - `NOP_INSN` = 32'h00000000;
  - `ADDR_ALIGN_MASK` = 32'hFFFFFFFC.
- One sub-module, `fetch_timer`:
  - 8-bit saturating up-counter with clear and enable;
  - asserts `expired` when the count equals `TIMEOUT`.
- The FSM, address register and instruction register stay in `instruction_fetch`.

## Test plan
- Reset, then `phase_f` with `pc`=0x00000104, memory acks in cycle 1 with 0xDEADBEEF -> `imem_addr`=0x104 in cycle 1; `ir`=0xDEADBEEF and `ir_valid`=1 in cycle 2; `fetch_busy` high only in cycle 1.
- `pc`=0x00000203, ack after 5 wait cycles -> `imem_addr`=0x200; `imem_req` and `fetch_busy` high for 6 cycles; `ir` updated on the 7th cycle.
- `TIMEOUT`=4, no ack -> `fetch_err`=1 five cycles after `imem_req` rises; `ir`=0; `ir_valid`=0; `imem_req`=0; `fetch_busy` stays 1; only `rst` clears.
- Ack on the exact timeout cycle -> normal completion, `fetch_err`=0.
- `hlt`=1 with `phase_f` in DONE -> no request; `hlt` asserted mid-REQ -> read completes, next `phase_f` ignored; extra `phase_f` during REQ -> `imem_addr` unchanged.
- `rst` pulsed asynchronously mid-REQ, then a late ack -> `imem_req` drops without waiting for a clock edge; `ir`=0, `ir_valid`=0, state IDLE; the late ack has no effect.
